// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: reset PC,
// FSM state encodings, datapath widths and a PC alignment helper.
package if_fetch_ctrl_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 20;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_e;

    // Every PC load is forced onto a word boundary.
    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
        return {pc[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues one word read per instruction,
// presents the fetched word to decode, and handles branch redirects that
// arrive while a read is in flight (the in-flight data is discarded).
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              read_ce,
    output logic [ADDR_W-1:0] address,
    input  logic              rfin,
    input  logic [WORD_W-1:0] data,
    input  logic              branch_flag,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              id_ready,
    output logic              inst_valid,
    output logic [WORD_W-1:0] inst,
    output logic [WORD_W-1:0] inst_pc
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] inst_q, inst_d;
    logic [WORD_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              read_ce_q, read_ce_d;
    logic              redirect_pend_q, redirect_pend_d;
    logic [WORD_W-1:0] redirect_tgt_q, redirect_tgt_d;

    // Next-state, PC-next mux and output-register inputs.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        inst_d          = inst_q;
        inst_pc_d       = inst_pc_q;
        inst_valid_d    = inst_valid_q;
        redirect_pend_d = redirect_pend_q;
        redirect_tgt_d  = redirect_tgt_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (rfin) begin
                    if (redirect_pend_q || branch_flag) begin
                        // Data belongs to the old stream: drop it and refetch.
                        if (branch_flag) begin
                            pc_d = align_pc(branch_target);
                        end else begin
                            pc_d = redirect_tgt_q;
                        end
                        redirect_pend_d = 1'b0;
                    end else begin
                        inst_d       = data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = align_pc(pc_q + 32'd4);
                        state_d      = ST_HOLD;
                    end
                end else if (branch_flag) begin
                    // Address must stay stable until rfin; remember the target.
                    redirect_pend_d = 1'b1;
                    redirect_tgt_d  = align_pc(branch_target);
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (branch_flag) begin
                    // Redirect wins over a simultaneous handoff.
                    inst_valid_d = 1'b0;
                    pc_d         = align_pc(branch_target);
                    state_d      = ST_REQ;
                end else if (id_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        read_ce_d = (state_d == ST_REQ);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            pc_q            <= RESET_PC;
            inst_q          <= 32'h0000_0000;
            inst_pc_q       <= 32'h0000_0000;
            inst_valid_q    <= 1'b0;
            read_ce_q       <= 1'b0;
            redirect_pend_q <= 1'b0;
            redirect_tgt_q  <= 32'h0000_0000;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            inst_q          <= inst_d;
            inst_pc_q       <= inst_pc_d;
            inst_valid_q    <= inst_valid_d;
            read_ce_q       <= read_ce_d;
            redirect_pend_q <= redirect_pend_d;
            redirect_tgt_q  <= redirect_tgt_d;
        end
    end

    assign read_ce    = read_ce_q;
    assign address    = pc_q[21:2];
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: a behavioural reference model and a
// fixed-latency memory model, a scoreboard of delivered instructions, a table
// of fetch/branch scenarios and a hand-written reset-during-read sequence.
module tb_if_fetch_ctrl;
    import if_fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_ce;
    logic [19:0] address;
    logic        rfin;
    logic [31:0] data;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        id_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    if_fetch_ctrl #(.RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst), .read_ce(read_ce), .address(address),
        .rfin(rfin), .data(data), .branch_flag(branch_flag),
        .branch_target(branch_target), .id_ready(id_ready),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model state (0 idle, 1 request, 2 hold)
    int          m_state;
    logic [31:0] m_pc, m_inst, m_ipc, m_tgt;
    logic        m_valid, m_pend;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } sb_t;
    sb_t sb_q[$];

    int   cnt;
    bit   mem_en;
    logic prev_valid;

    function automatic logic [31:0] mem_data(input logic [19:0] a);
        return 32'h2408_0001 ^ {a, 12'h000};
    endfunction

    task automatic model_reset();
        m_state = 0; m_pc = 32'h8000_0000; m_inst = 32'h0; m_ipc = 32'h0;
        m_tgt = 32'h0; m_valid = 1'b0; m_pend = 1'b0;
        sb_q.delete();
        prev_valid = 1'b0;
    endtask

    // One clock: predict, advance, compare, then update memory-model inputs.
    task automatic tick();
        int          ns;
        logic [31:0] npc, ninst, nipc, ntgt;
        logic        nv, np;
        sb_t         e;
        ns = m_state; npc = m_pc; ninst = m_inst; nipc = m_ipc;
        ntgt = m_tgt; nv = m_valid; np = m_pend;
        if (rst) begin
            ns = 0; npc = 32'h8000_0000; ninst = 32'h0; nipc = 32'h0;
            ntgt = 32'h0; nv = 1'b0; np = 1'b0;
        end else begin
            case (m_state)
                0: ns = 1;
                1: begin
                    if (rfin) begin
                        if (m_pend || branch_flag) begin
                            npc = branch_flag ? {branch_target[31:2], 2'b00} : m_tgt;
                            np  = 1'b0;
                        end else begin
                            ninst = data; nipc = m_pc; nv = 1'b1;
                            npc = m_pc + 32'd4; ns = 2;
                            sb_q.push_back('{inst: data, pc: m_pc});
                        end
                    end else if (branch_flag) begin
                        np = 1'b1; ntgt = {branch_target[31:2], 2'b00};
                    end
                end
                2: begin
                    if (branch_flag) begin
                        nv = 1'b0; npc = {branch_target[31:2], 2'b00}; ns = 1;
                    end else if (id_ready) begin
                        nv = 1'b0; ns = 1;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        m_state = ns; m_pc = npc; m_inst = ninst; m_ipc = nipc;
        m_tgt = ntgt; m_valid = nv; m_pend = np;
        branch_flag = 1'b0;

        check("cycle{read_ce,inst_valid,address}", {read_ce, inst_valid, address},
              {(m_state == 1), m_valid, m_pc[21:2]});
        if (m_valid) check("held{inst,inst_pc}", {inst, inst_pc}, {m_inst, m_ipc});

        if (inst_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_empty: delivery of %h at %h with nothing expected", inst, inst_pc);
            end else begin
                e = sb_q.pop_front();
                check("sb_delivery", {inst, inst_pc}, {e.inst, e.pc});
            end
        end
        prev_valid = inst_valid;

        if (mem_en) begin
            if (read_ce && !rfin) cnt++;
            else cnt = 0;
            rfin = (cnt == 4);
            data = mem_data(address);
        end
    endtask

    typedef struct {
        bit          br_req;
        int          br_dly;
        logic [31:0] tgt;
        bit          br2;
        logic [31:0] tgt2;
        int          hold_cyc;
        bit          br_hold;
        logic [31:0] htgt;
        logic [31:0] exp_ipc;
        logic [19:0] exp_next;
    } scn_t;

    scn_t scns[8];

    // Starts with the DUT in REQ; ends one cycle after the handoff.
    task automatic run_scn(input int idx, input scn_t s);
        id_ready = 1'b0;
        if (s.br_req) begin
            repeat (s.br_dly) tick();
            branch_flag = 1'b1; branch_target = s.tgt;
            tick();
            if (s.br2) begin
                branch_flag = 1'b1; branch_target = s.tgt2;
                tick();
            end
        end
        for (int i = 0; i < 40 && !inst_valid; i++) tick();
        if (!inst_valid) begin
            n_checks++;
            $display("FAIL scn%0d_timeout: inst_valid stayed 0, expected 1", idx);
        end
        check($sformatf("scn%0d_inst_pc", idx), inst_pc, s.exp_ipc);
        repeat (s.hold_cyc) tick();
        id_ready = 1'b1;
        if (s.br_hold) begin
            branch_flag = 1'b1; branch_target = s.htgt;
        end
        tick();
        id_ready = 1'b0;
        check($sformatf("scn%0d_valid_after_handoff", idx), inst_valid, 1'b0);
        check($sformatf("scn%0d_read_ce_after_handoff", idx), read_ce, 1'b1);
        check($sformatf("scn%0d_next_addr", idx), address, s.exp_next);
    endtask

    initial begin
        // br_req dly tgt br2 tgt2 hold br_hold htgt exp_ipc exp_next
        scns[0] = '{1'b0, 0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 32'h8000_0000, 20'h00001};
        scns[1] = '{1'b0, 0, 32'h0, 1'b0, 32'h0, 5, 1'b0, 32'h0, 32'h8000_0004, 20'h00002};
        scns[2] = '{1'b1, 1, 32'h8000_0100, 1'b0, 32'h0, 0, 1'b0, 32'h0, 32'h8000_0100, 20'h00041};
        scns[3] = '{1'b0, 0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 32'h8000_0200, 32'h8000_0104, 20'h00080};
        scns[4] = '{1'b1, 0, 32'h8000_0303, 1'b1, 32'h8000_0400, 0, 1'b0, 32'h0, 32'h8000_0400, 20'h00101};
        scns[5] = '{1'b0, 0, 32'h0, 1'b0, 32'h0, 1, 1'b1, 32'hFFFF_FFFC, 32'h8000_0404, 20'hFFFFF};
        scns[6] = '{1'b0, 0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 32'hFFFF_FFFC, 20'h00000};
        scns[7] = '{1'b1, 3, 32'h8000_0500, 1'b0, 32'h0, 0, 1'b0, 32'h0, 32'h8000_0500, 20'h00141};

        rst = 1'b1; rfin = 1'b0; data = 32'h0; branch_flag = 1'b0;
        branch_target = 32'h0; id_ready = 1'b0; mem_en = 1'b1; cnt = 0;
        model_reset();
        #1;
        check("reset_outputs", {read_ce, inst_valid, address, inst, inst_pc},
              {1'b0, 1'b0, 20'h00000, 32'h0, 32'h0});
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5 && !read_ce; i++) tick();
        check("first_read_ce", read_ce, 1'b1);
        check("first_address", address, 20'h00000);

        for (int k = 0; k < 8; k++) run_scn(k, scns[k]);

        // Reset while a read is outstanding; rfin arriving during reset is ignored.
        tick();
        mem_en = 1'b0; rfin = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check("midreq_rst_outputs", {read_ce, inst_valid}, {1'b0, 1'b0});
        rfin = 1'b1; data = 32'hDEAD_BEEF;
        tick();
        rfin = 1'b0;
        tick();
        check("rst_no_capture", {inst_valid, inst, inst_pc}, {1'b0, 32'h0, 32'h0});
        rst = 1'b0; cnt = 0; mem_en = 1'b1;
        tick();
        check("post_rst_req", {read_ce, inst_valid, address}, {1'b1, 1'b0, 20'h00000});
        run_scn(8, scns[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
